// File: rtl/svc_uart_rx_pkg.sv
// rtl/svc_uart_rx_pkg.sv - shared definitions for the UART receive peripheral
// Purpose : register offsets, STATUS bit positions and receiver FSM states
//           used by svc_uart_rx_core and svc_soc_uart_rx_reg.
// Ports   : none (package).
package svc_uart_rx_pkg;

    localparam logic [3:0] REG_RXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    // STATUS register bit positions
    localparam int STAT_OVERRUN   = 0;
    localparam int STAT_FRAME_ERR = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/svc_uart_rx_core.sv
// rtl/svc_uart_rx_core.sv - 8N1 deserializer with input synchronizer
// Purpose : synchronizes the async rx pin, times bit centres with a baud
//           counter and assembles bytes LSB first.
// Ports   : i_clk, i_rst      - core clock, synchronous active-high reset
//           i_rx              - async serial input, idle high
//           o_byte_valid      - 1-cycle pulse, o_byte_data holds a good byte
//           o_byte_data [7:0] - received byte
//           o_frame_err       - 1-cycle pulse on a stop bit sampled low
module svc_uart_rx_core
    import svc_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    logic w_rx;
    assign w_rx = r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Sync flops preset to the idle line level so reset does not
            // look like a start bit.
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_byte_data  <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state <= START;
                        r_cnt   <= HALF_BIT;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_rx) begin
                        // Still low at mid start bit: genuine frame.
                        r_state   <= DATA;
                        r_cnt     <= FULL_BIT;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= FULL_BIT;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx) begin
                        o_byte_valid <= 1'b1;
                        o_byte_data  <= r_shift;
                        r_state      <= IDLE;
                    end else begin
                        o_frame_err <= 1'b1;
                        r_state     <= BREAK;
                    end
                end
                BREAK: begin
                    // Hold off new start detection until the line is released.
                    if (w_rx) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/svc_soc_uart_rx_reg.sv
// rtl/svc_soc_uart_rx_reg.sv - UART receive peripheral on the SoC I/O bus
// Purpose : buffers received bytes in a FIFO and exposes RXDATA (pop on read)
//           and STATUS (occupancy, full, W1C sticky errors) registers.
// Ports   : clk, rst              - core clock, synchronous active-high reset
//           io_ren/io_raddr       - read strobe and byte address
//           io_rdata              - read data, registered, 1 cycle after io_ren
//           io_wen/io_waddr/io_wdata/io_wstrb - write port (STATUS W1C only)
//           uart_rx               - async serial input, idle high
//           rx_irq                - FIFO non-empty or any sticky error
module svc_soc_uart_rx_reg
    import svc_uart_rx_pkg::*;
#(
    parameter int          CLOCK_FREQ = 100_000_000,
    parameter int          BAUD_RATE  = 115_200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW           = $clog2(FIFO_DEPTH);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("svc_soc_uart_rx_reg: CLKS_PER_BIT must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("svc_soc_uart_rx_reg: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;

    svc_uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (uart_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    // FIFO: pointers carry one extra MSB so full and empty are distinct.
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));

    logic w_rhit;
    logic w_whit;
    logic w_pop;
    logic w_push;
    logic w_ovr_set;
    logic w_ovr_clr;
    logic w_ferr_clr;

    assign w_rhit = (io_raddr[31:4] == BASE_ADDR[31:4]);
    assign w_whit = (io_waddr[31:4] == BASE_ADDR[31:4]);
    assign w_pop  = io_ren && w_rhit && (io_raddr[3:0] == REG_RXDATA) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_byte_valid && (!w_full || w_pop);
    assign w_ovr_set = w_byte_valid && w_full && !w_pop;

    logic w_status_w1c;
    assign w_status_w1c = io_wen && w_whit && (io_waddr[3:0] == REG_STATUS) && io_wstrb[0];
    assign w_ovr_clr    = w_status_w1c && io_wdata[0];
    assign w_ferr_clr   = w_status_w1c && io_wdata[1];

    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            // Set wins over a simultaneous W1C.
            r_overrun   <= w_ovr_set   | (r_overrun   & ~w_ovr_clr);
            r_frame_err <= w_frame_err | (r_frame_err & ~w_ferr_clr);
        end
    end

    logic [31:0] w_status;
    always_comb begin
        w_status                   = '0;
        w_status[31:STAT_COUNT_LSB] = 16'(w_count);
        w_status[STAT_FULL]        = w_full;
        w_status[STAT_FRAME_ERR]   = r_frame_err;
        w_status[STAT_OVERRUN]     = r_overrun;
    end

    logic [31:0] r_rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (io_ren && w_rhit) begin
            case (io_raddr[3:0])
                REG_RXDATA: r_rdata <= w_empty ? 32'd0
                                               : {23'd0, 1'b1, r_mem[r_rptr[AW-1:0]]};
                REG_STATUS: r_rdata <= w_status;
                default:    r_rdata <= '0;
            endcase
        end else begin
            r_rdata <= '0;
        end
    end

    assign io_rdata = r_rdata;
    assign rx_irq   = !w_empty || r_overrun || r_frame_err;

    logic w_unused;
    assign w_unused = ^{io_wstrb[3:1], io_wdata[31:2]};

endmodule

// File: tb/tb_svc_soc_uart_rx_reg.sv
// tb/tb_svc_soc_uart_rx_reg.sv - scoreboard bench for svc_soc_uart_rx_reg
module tb_svc_soc_uart_rx_reg;

    localparam int          CLOCK_FREQ = 1_600_000;
    localparam int          BAUD_RATE  = 100_000;
    localparam int          CPB        = CLOCK_FREQ / BAUD_RATE;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] BASE       = 32'h0000_0100;
    localparam logic [31:0] A_RXDATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS   = BASE + 32'h4;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_ren;
    logic [31:0] io_raddr;
    logic [31:0] io_rdata;
    logic        io_wen;
    logic [31:0] io_waddr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        uart_rx;
    logic        rx_irq;

    svc_soc_uart_rx_reg #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_ren   (io_ren),
        .io_raddr (io_raddr),
        .io_rdata (io_rdata),
        .io_wen   (io_wen),
        .io_waddr (io_waddr),
        .io_wdata (io_wdata),
        .io_wstrb (io_wstrb),
        .uart_rx  (uart_rx),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // Monitor: io_rdata is valid the cycle after a sampled io_ren.
    logic        ren_d = 1'b0;
    logic [31:0] mon_exp;
    string       mon_name;
    always @(posedge clk) ren_d <= io_ren;
    always @(negedge clk) begin
        if (ren_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=0x%08h required=no read", io_rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (io_rdata !== mon_exp) begin
                    failures++;
                    $display("FAIL %s got=0x%08h required=0x%08h", mon_name, io_rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        io_ren   = 1'b1;
        io_raddr = a;
        tick(1);
        io_ren   = 1'b0;
        io_raddr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        io_wen   = 1'b1;
        io_waddr = a;
        io_wdata = d;
        io_wstrb = s;
        tick(1);
        io_wen   = 1'b0;
        io_wstrb = '0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s got=0x%08h required=0x%08h", n, act, e);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int hold_low_bits);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        if (!stop) tick(hold_low_bits * CPB);
        uart_rx = 1'b1;
        tick(CPB);
    endtask

    initial begin
        rst = 1'b1; io_ren = 1'b0; io_raddr = '0; io_wen = 1'b0;
        io_waddr = '0; io_wdata = '0; io_wstrb = '0; uart_rx = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);

        // reset state
        chk("rst_irq", {31'd0, rx_irq}, 32'd0);
        rd(A_STATUS, 32'h0000_0000, "rst_status");
        rd(A_RXDATA, 32'h0000_0000, "rst_rxdata");

        // single byte 0xA5
        send(8'hA5, 1'b1, 0);
        chk("a5_irq_set", {31'd0, rx_irq}, 32'd1);
        rd(A_STATUS, 32'h0001_0000, "a5_status");
        rd(32'h0000_0200, 32'h0, "out_of_window");
        rd(BASE + 32'h8, 32'h0, "reg8");
        wr(A_RXDATA, 32'hFFFF_FFFF, 4'hF);
        rd(A_STATUS, 32'h0001_0000, "a5_status_no_side_effect");
        rd(A_RXDATA, 32'h0000_01A5, "a5_rxdata");
        rd(A_STATUS, 32'h0000_0000, "a5_status_after");
        chk("a5_irq_clear", {31'd0, rx_irq}, 32'd0);
        rd(A_RXDATA, 32'h0, "rxdata_empty");

        // short glitch on idle line
        uart_rx = 1'b0;
        tick(5);
        uart_rx = 1'b1;
        tick(3 * CPB);
        rd(A_STATUS, 32'h0, "glitch_status");
        chk("glitch_irq", {31'd0, rx_irq}, 32'd0);

        // framing error then a good byte
        send(8'h3C, 1'b0, 1);
        rd(A_STATUS, 32'h0000_0002, "ferr_status");
        chk("ferr_irq", {31'd0, rx_irq}, 32'd1);
        send(8'h55, 1'b1, 0);
        rd(A_STATUS, 32'h0001_0002, "ferr_then_55_status");
        rd(A_RXDATA, 32'h0000_0155, "rx_55");
        wr(A_STATUS, 32'h2, 4'h2);
        rd(A_STATUS, 32'h0000_0002, "w1c_wrong_strb");
        wr(A_STATUS, 32'h2, 4'h1);
        rd(A_STATUS, 32'h0, "w1c_ferr_cleared");

        // overrun
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 0);
        rd(A_STATUS, 32'h0004_0005, "ovr_status");
        for (int i = 1; i <= 4; i++) rd(A_RXDATA, 32'h100 + 32'(i), "ovr_rxdata");
        rd(A_RXDATA, 32'h0, "ovr_drained");
        rd(A_STATUS, 32'h0000_0001, "ovr_sticky");
        wr(A_STATUS, 32'h1, 4'h1);
        rd(A_STATUS, 32'h0, "ovr_cleared");

        // pop and push in the same cycle on a full FIFO
        for (int i = 1; i <= 4; i++) send(8'h10 + 8'(i), 1'b1, 0);
        rd(A_STATUS, 32'h0004_0004, "full_status");
        fork
            send(8'h15, 1'b1, 0);
            begin
                int k;
                k = 0;
                while (dut.w_byte_valid !== 1'b1 && k < 20 * CPB) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 20 * CPB) begin
                    checks++;
                    failures++;
                    $display("FAIL popush_wait got=timeout required=byte_valid");
                end else begin
                    exp_q.push_back(32'h0000_0111);
                    name_q.push_back("popush_rxdata");
                    io_ren   = 1'b1;
                    io_raddr = A_RXDATA;
                    @(posedge clk);
                    #1;
                    io_ren   = 1'b0;
                    io_raddr = '0;
                end
            end
        join
        rd(A_STATUS, 32'h0004_0004, "popush_status");
        for (int i = 2; i <= 5; i++) rd(A_RXDATA, 32'h110 + 32'(i), "popush_drain");
        rd(A_STATUS, 32'h0, "popush_empty");

        // reset in the middle of a frame
        send(8'h42, 1'b1, 0);
        rd(A_STATUS, 32'h0001_0000, "pre_rst_status");
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            tick(CPB);
        end
        uart_rx = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2 * CPB);
        rd(A_STATUS, 32'h0, "mid_rst_status");
        chk("mid_rst_irq", {31'd0, rx_irq}, 32'd0);
        send(8'h7E, 1'b1, 0);
        rd(A_STATUS, 32'h0001_0000, "after_rst_status");
        rd(A_RXDATA, 32'h0000_017E, "after_rst_7e");

        tick(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
